// File: rtl/voice_allocator.sv
// Voice allocator: pops note commands from a write FIFO and assigns them to tone voices
// with retrigger / free-voice / oldest-voice-steal priority, one command every three cycles.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                cmd_data,
  input  logic                       cmd_empty,
  output logic                       cmd_rden,
  output logic [NUM_VOICES*23-1:0]   voice_period,
  output logic [NUM_VOICES-1:0]      voice_gate,
  output logic [NUM_VOICES-1:0]      voice_on,
  output logic [NUM_VOICES-1:0]      voice_off,
  output logic [7:0]                 steal_count,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  state_t                  state;
  logic [22:0]             period  [NUM_VOICES];
  logic [6:0]              note_id [NUM_VOICES];
  logic [AGE_W-1:0]        age     [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate;
  logic [NUM_VOICES-1:0]   on_q;
  logic [NUM_VOICES-1:0]   off_q;

  // FIFO handshake: cmd_rden is a read strobe raised only in IDLE while the FIFO is
  // non-empty; the word it pops is presented on cmd_data one cycle later (in LATCH).
  assign cmd_rden  = ~rst & (state == ST_IDLE) & ~cmd_empty;
  assign busy      = ~rst & ((state != ST_IDLE) | cmd_rden);
  assign state_dbg = state;

  // Command decode straight off cmd_data; it is only consumed on the LATCH edge.
  logic [1:0]  op;
  logic [6:0]  cmd_note;
  logic [22:0] cmd_period;
  logic        is_on;
  logic        is_off;
  logic        is_alloff;

  assign op         = cmd_data[31:30];
  assign cmd_note   = cmd_data[29:23];
  assign cmd_period = cmd_data[22:0];
  assign is_on      = (op == 2'b01) && (cmd_period != 23'd0);
  assign is_off     = (op == 2'b00) || ((op == 2'b01) && (cmd_period == 23'd0));
  assign is_alloff  = (op == 2'b10);

  logic [NUM_VOICES-1:0] match;
  logic                  hit_found;
  logic                  free_found;
  logic [IDX_W-1:0]      hit_idx;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W-1:0]      old_idx;
  logic [AGE_W-1:0]      old_age;
  logic [IDX_W-1:0]      sel_idx;
  logic                  steal;

  always_comb begin
    match      = '0;
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = age[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      match[v] = gate[v] && (note_id[v] == cmd_note);
      if (match[v] && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(v);
      end
      if (!gate[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(v);
      end
    end
    // Strict compare keeps the lowest index on age ties; only used when every voice is gated.
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > old_age) begin
        old_age = age[v];
        old_idx = IDX_W'(v);
      end
    end
    steal   = !hit_found && !free_found;
    sel_idx = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
  end

  // Voice state and pulses are registered on the LATCH->APPLY edge so they appear in APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      gate        <= '0;
      on_q        <= '0;
      off_q       <= '0;
      steal_count <= 8'd0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        period[v]  <= 23'd0;
        note_id[v] <= 7'd0;
        age[v]     <= '0;
      end
    end else begin
      on_q  <= '0;
      off_q <= '0;
      unique case (state)
        ST_IDLE: begin
          if (!cmd_empty) state <= ST_LATCH;
        end
        ST_LATCH: begin
          state <= ST_APPLY;
          if (is_on) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (IDX_W'(v) == sel_idx) begin
                period[v]  <= cmd_period;
                note_id[v] <= cmd_note;
                gate[v]    <= 1'b1;
                age[v]     <= '0;
                on_q[v]    <= 1'b1;
                off_q[v]   <= steal;
              end else if (gate[v] && (age[v] != AGE_MAX)) begin
                age[v] <= age[v] + 1'b1;
              end
            end
            if (steal && (steal_count != 8'hFF)) steal_count <= steal_count + 8'd1;
          end else if (is_off) begin
            gate  <= gate & ~match;
            off_q <= match;
          end else if (is_alloff) begin
            gate  <= '0;
            off_q <= gate;
          end
        end
        ST_APPLY: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pulses are suppressed while rst is high so a command caught by reset in APPLY emits nothing.
  assign voice_gate = gate;
  assign voice_on   = on_q & {NUM_VOICES{~rst}};
  assign voice_off  = off_q & {NUM_VOICES{~rst}};

  always_comb begin
    voice_period = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_period[23*v +: 23] = period[v];
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: FIFO model, behavioural allocation model feeding an expected
// queue, and a monitor that scores every APPLY cycle against it.
module tb_voice_allocator;

  localparam int NV      = 4;
  localparam int AW      = 8;
  localparam int AGE_MAX = (1 << AW) - 1;
  localparam int EXP_W   = 8 + 3*NV + 23*NV;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [31:0]          cmd_data = '0;
  logic                 cmd_empty = 1'b1;
  logic                 cmd_rden;
  logic [NV*23-1:0]     voice_period;
  logic [NV-1:0]        voice_gate;
  logic [NV-1:0]        voice_on;
  logic [NV-1:0]        voice_off;
  logic [7:0]           steal_count;
  logic                 busy;
  logic [1:0]           state_dbg;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_data     (cmd_data),
    .cmd_empty    (cmd_empty),
    .cmd_rden     (cmd_rden),
    .voice_period (voice_period),
    .voice_gate   (voice_gate),
    .voice_on     (voice_on),
    .voice_off    (voice_off),
    .steal_count  (steal_count),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]      fifo_q[$];
  logic [EXP_W-1:0] exp_q[$];

  // Command FIFO: word appears on cmd_data the cycle after the read strobe.
  always @(posedge clk) begin
    if (cmd_rden && (fifo_q.size() > 0)) cmd_data <= fifo_q.pop_front();
    #2;
    cmd_empty = (fifo_q.size() == 0);
  end

  task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit          m_gate   [NV];
  int          m_note   [NV];
  logic [22:0] m_period [NV];
  int          m_age    [NV];
  int          m_steals;

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 1'b0; m_note[v] = 0; m_period[v] = '0; m_age[v] = 0;
    end
    m_steals = 0;
  endfunction

  function automatic logic [EXP_W-1:0] model_cmd(input logic [31:0] cmd);
    logic [NV-1:0]    on;
    logic [NV-1:0]    off;
    logic [NV-1:0]    g;
    logic [NV*23-1:0] per;
    int op, id, p, sel;
    bit stolen;
    op = int'(cmd[31:30]); id = int'(cmd[29:23]); p = int'(cmd[22:0]);
    on = '0; off = '0; sel = -1; stolen = 1'b0;
    if (op == 1 && p != 0) begin
      for (int v = 0; v < NV; v++) if (sel < 0 && m_gate[v] && m_note[v] == id) sel = v;
      for (int v = 0; v < NV; v++) if (sel < 0 && !m_gate[v]) sel = v;
      if (sel < 0) begin
        stolen = 1'b1; sel = 0;
        for (int v = 1; v < NV; v++) if (m_age[v] > m_age[sel]) sel = v;
      end
      for (int v = 0; v < NV; v++)
        if (v != sel && m_gate[v] && m_age[v] < AGE_MAX) m_age[v] = m_age[v] + 1;
      m_gate[sel] = 1'b1; m_note[sel] = id; m_period[sel] = cmd[22:0]; m_age[sel] = 0;
      on[sel] = 1'b1;
      if (stolen) begin
        off[sel] = 1'b1;
        if (m_steals < 255) m_steals++;
      end
    end else if (op == 0 || op == 1) begin
      for (int v = 0; v < NV; v++)
        if (m_gate[v] && m_note[v] == id) begin m_gate[v] = 1'b0; off[v] = 1'b1; end
    end else if (op == 2) begin
      for (int v = 0; v < NV; v++) begin off[v] = m_gate[v]; m_gate[v] = 1'b0; end
    end
    for (int v = 0; v < NV; v++) begin
      per[23*v +: 23] = m_period[v];
      g[v] = m_gate[v];
    end
    return {8'(m_steals), g, off, on, per};
  endfunction

  function automatic logic [31:0] mk(input int op, input int id, input int p);
    return {2'(op), 7'(id), 23'(p)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] cmd);
    exp_q.push_back(model_cmd(cmd));
    fifo_q.push_back(cmd);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && cmd_empty && state_dbg == 2'd0) done = 1'b1;
    end
    check("idle_reached", EXP_W'(done), EXP_W'(1));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (state_dbg == 2'd2) begin
        check("apply_expected", EXP_W'(exp_q.size() > 0), EXP_W'(1));
        if (exp_q.size() > 0)
          check("apply_outputs", {steal_count, voice_gate, voice_off, voice_on, voice_period},
                exp_q.pop_front());
      end else begin
        check("no_pulse_outside_apply", EXP_W'({voice_on, voice_off}), EXP_W'(0));
      end
      if (cmd_rden) check("rden_only_in_idle", EXP_W'(state_dbg), EXP_W'(0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {steal_count, voice_gate, voice_off, voice_on, voice_period}, '0);
    check("reset_rden_busy", EXP_W'({cmd_rden, busy}), EXP_W'(0));
    @(posedge clk); #1; rst = 1'b0;
    wait_idle();

    // First note-on: strobe, then voice_on two cycles later.
    @(posedge clk); #1; send(mk(1, 60, 1000));
    @(negedge clk); check("first_rden", EXP_W'(cmd_rden), EXP_W'(1));
    @(negedge clk); check("first_on_not_early", EXP_W'(voice_on), EXP_W'(0));
    @(negedge clk);
    check("first_on_pulse", EXP_W'(voice_on), EXP_W'(4'b0001));
    check("first_period", EXP_W'(voice_period[22:0]), EXP_W'(1000));
    check("first_gate", EXP_W'(voice_gate), EXP_W'(4'b0001));
    wait_idle();

    // Fill all voices, then steal the oldest.
    send(mk(1, 62, 100)); send(mk(1, 64, 200)); send(mk(1, 65, 300));
    send(mk(1, 67, 500));
    wait_idle();
    check("steal_count_one", EXP_W'(steal_count), EXP_W'(1));
    check("stolen_period0", EXP_W'(voice_period[22:0]), EXP_W'(500));

    // Retrigger of a held note.
    send(mk(1, 62, 777));
    wait_idle();
    check("retrig_period1", EXP_W'(voice_period[45:23]), EXP_W'(777));
    check("retrig_no_steal", EXP_W'(steal_count), EXP_W'(1));

    // Re-acquire 60 (steals voice 2), unmatched note-off, then note-on period 0 as note-off.
    send(mk(1, 60, 1000));
    send(mk(0, 99, 0));
    send(mk(1, 60, 0));
    wait_idle();
    check("period0_off_gate", EXP_W'(voice_gate), EXP_W'(4'b1011));
    check("steal_count_two", EXP_W'(steal_count), EXP_W'(2));

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      int sel, id, p;
      sel = $urandom_range(0, 9);
      id  = $urandom_range(60, 67);
      p   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 23'h7FFFFF);
      @(posedge clk); #1;
      if (sel <= 5)      send(mk(1, id, p));
      else if (sel <= 7) send(mk(0, id, p));
      else if (sel == 8) send(mk(2, id, p));
      else               send(mk(3, id, p));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();

    // Back-to-back commands: strobe every third cycle, busy throughout.
    @(posedge clk); #1;
    send(mk(1, 70, 11)); send(mk(3, 5, 5)); send(mk(0, 70, 0));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("b2b_rden", EXP_W'(cmd_rden), EXP_W'((k < 9 && k % 3 == 0) ? 1 : 0));
      check("b2b_busy", EXP_W'(busy), EXP_W'((k < 9) ? 1 : 0));
    end
    wait_idle();

    // Reset during APPLY of an all-off.
    send(mk(1, 40, 123)); send(mk(1, 41, 456));
    wait_idle();
    @(posedge clk); #1; send(mk(2, 0, 0));
    @(posedge clk);
    @(posedge clk); #1;
    check("in_apply_before_rst", EXP_W'(state_dbg), EXP_W'(2));
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check("rst_apply_no_pulse", EXP_W'({voice_on, voice_off}), EXP_W'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", {steal_count, voice_gate, voice_off, voice_on, voice_period}, '0);
    check("post_rst_state", EXP_W'({state_dbg, busy, cmd_rden}), EXP_W'(0));

    send(mk(1, 50, 42));
    wait_idle();
    check("scoreboard_drained", EXP_W'(exp_q.size()), EXP_W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
